calc_input_fsm: RTL and testbench



---
 rtl/calc_pkg.sv | 27 ++
 rtl/calc_alu.sv | 61 ++++++
 rtl/calc_input_fsm.sv | 132 +++++++++++++
 tb/tb_calc_input_fsm.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator front-end.
// The optional status flags are enabled with CALC_FLAGS_EN.
package calc_pkg;

    localparam int unsigned CALC_W = 16;

    typedef enum logic [2:0] {
        S_OP1_EDIT = 3'b000,
        S_OP1_HOLD = 3'b001,
        S_OP2_EDIT = 3'b010,
        S_OP2_HOLD = 3'b011,
        S_OPR_EDIT = 3'b100,
        S_RESULT   = 3'b101
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    function automatic alu_op_t sel_to_op(input logic [1:0] sel);
        return alu_op_t'(sel);
    endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational calculator ALU: ADD/SUB/AND/OR, truncated to WIDTH bits.
// With CALC_FLAGS_EN defined it also produces {N,Z,C,V}.
module calc_alu
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = CALC_W
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] y_o
`ifdef CALC_FLAGS_EN
    ,
    output logic [3:0]       flags_o
`endif
);

`ifdef CALC_FLAGS_EN
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           carry;
    logic           ovf;

    always_comb begin
        sum   = {1'b0, a_i} + {1'b0, b_i};
        diff  = {1'b0, a_i} - {1'b0, b_i};
        y_o   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (sel_to_op(op_i))
            ALU_ADD: begin
                y_o   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (y_o[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_SUB: begin
                y_o   = diff[WIDTH-1:0];
                // Carry is NOT-borrow: set when a >= b unsigned.
                carry = ~diff[WIDTH];
                ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (y_o[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            default: y_o = '0;
        endcase
        flags_o = {y_o[WIDTH-1], (y_o == '0), carry, ovf};
    end
`else
    always_comb begin
        y_o = '0;
        case (sel_to_op(op_i))
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            default: y_o = '0;
        endcase
    end
`endif

endmodule

// File: rtl/calc_input_fsm.sv
// Calculator input sequencer: captures op1, op2 and operation from the switches on successive
// Enter presses and registers the ALU result. Flags port present only with CALC_FLAGS_EN.
module calc_input_fsm
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = CALC_W
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [WIDTH-1:0] sw,
    input  logic             enter,
    output logic [2:0]       state,
    output logic [WIDTH-1:0] op1,
    output logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] operation,
    output logic [WIDTH-1:0] result
`ifdef CALC_FLAGS_EN
    ,
    output logic [3:0]       flags
`endif
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic [WIDTH-1:0] operation_q, operation_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             enter_q;
    logic             armed_q, armed_d;
    logic             press;
    logic [WIDTH-1:0] alu_y;

`ifdef CALC_FLAGS_EN
    logic [3:0] flags_q, flags_d;
    logic [3:0] alu_flags;
`endif

    // ALU sees the live switch selector so the result uses the operation chosen in the press cycle.
    calc_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a_i     (op1_q),
        .b_i     (op2_q),
        .op_i    (sw[1:0]),
        .y_o     (alu_y)
`ifdef CALC_FLAGS_EN
        ,
        .flags_o (alu_flags)
`endif
    );

    // A level held high across reset release is not a press: arm only after enter is seen low.
    assign armed_d = armed_q | ~enter;
    assign press   = enter & ~enter_q & armed_q;

    always_comb begin
        state_d     = state_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        operation_d = operation_q;
        result_d    = result_q;
`ifdef CALC_FLAGS_EN
        flags_d     = flags_q;
`endif
        case (state_q)
            S_OP1_EDIT: begin
                op1_d = sw;
                if (press) state_d = S_OP1_HOLD;
            end
            S_OP1_HOLD: begin
                if (press) state_d = S_OP2_EDIT;
            end
            S_OP2_EDIT: begin
                op2_d = sw;
                if (press) state_d = S_OP2_HOLD;
            end
            S_OP2_HOLD: begin
                if (press) state_d = S_OPR_EDIT;
            end
            S_OPR_EDIT: begin
                operation_d = sw;
                if (press) begin
                    state_d  = S_RESULT;
                    result_d = alu_y;
`ifdef CALC_FLAGS_EN
                    flags_d  = alu_flags;
`endif
                end
            end
            S_RESULT: begin
                if (press) state_d = S_OP1_EDIT;
            end
            default: state_d = S_OP1_EDIT;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= S_OP1_EDIT;
            op1_q       <= '0;
            op2_q       <= '0;
            operation_q <= '0;
            result_q    <= '0;
            enter_q     <= 1'b0;
            armed_q     <= 1'b0;
`ifdef CALC_FLAGS_EN
            flags_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            operation_q <= operation_d;
            result_q    <= result_d;
            enter_q     <= enter;
            armed_q     <= armed_d;
`ifdef CALC_FLAGS_EN
            flags_q     <= flags_d;
`endif
        end
    end

    assign state     = state_q;
    assign op1       = op1_q;
    assign op2       = op2_q;
    assign operation = operation_q;
    assign result    = result_q;
`ifdef CALC_FLAGS_EN
    assign flags     = flags_q;
`endif

endmodule

// File: tb/tb_calc_input_fsm.sv
// Self-checking bench for calc_input_fsm; expected results go through a scoreboard queue.
// Define CALC_FLAGS_EN to also check the flags port.
module tb_calc_input_fsm;

    logic        clk = 1'b0;
    logic        resetN;
    logic [15:0] sw;
    logic        enter;
    logic [2:0]  state;
    logic [15:0] op1, op2, operation, result;
`ifdef CALC_FLAGS_EN
    logic [3:0]  flags;
`endif

    int unsigned passed = 0;
    int unsigned total  = 0;

    typedef struct {
        logic [15:0] op1;
        logic [15:0] op2;
        logic [15:0] opr;
        logic [15:0] res;
        logic [3:0]  flg;
    } exp_t;

    exp_t sb_q[$];

    calc_input_fsm dut (
        .clk       (clk),
        .resetN    (resetN),
        .sw        (sw),
        .enter     (enter),
        .state     (state),
        .op1       (op1),
        .op2       (op2),
        .operation (operation),
        .result    (result)
`ifdef CALC_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_press();
        enter = 1'b1;
        step();
        enter = 1'b0;
        step();
    endtask

    // Independent reference using wide integer arithmetic.
    function automatic logic [15:0] model_res(input logic [15:0] a, input logic [15:0] b,
                                              input logic [15:0] s);
        int r;
        case (s[1:0])
            2'd0:    r = int'(a) + int'(b);
            2'd1:    r = int'(a) - int'(b);
            2'd2:    r = int'(a & b);
            default: r = int'(a | b);
        endcase
        return r[15:0];
    endfunction

    function automatic logic [3:0] model_flg(input logic [15:0] a, input logic [15:0] b,
                                             input logic [15:0] s);
        logic [15:0] r;
        int          sa, sb, sr;
        logic        c, v;
        r  = model_res(a, b, s);
        sa = int'($signed(a));
        sb = int'($signed(b));
        c  = 1'b0;
        v  = 1'b0;
        if (s[1:0] == 2'd0) begin
            c  = (int'(a) + int'(b)) > 65535;
            sr = sa + sb;
            v  = (sr > 32767) || (sr < -32768);
        end else if (s[1:0] == 2'd1) begin
            c  = a >= b;
            sr = sa - sb;
            v  = (sr > 32767) || (sr < -32768);
        end
        return {r[15], r == 16'h0000, c, v};
    endfunction

    task automatic goto_op1_edit();
        int n = 0;
        while (state !== 3'b000 && n < 8) begin
            do_press();
            n++;
        end
        if (state !== 3'b000) begin
            total++;
            $display("FAIL goto_op1_edit: state=%b required 000 within 8 presses", state);
        end
    endtask

    task automatic run_calc(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s,
                            input logic [15:0] exp_res);
        exp_t e;
        exp_t g;
        int   n;
        goto_op1_edit();
        sw = a;
        step();
        do_press();
        do_press();
        sw = b;
        step();
        do_press();
        do_press();
        sw = s;
        step();
        e.op1 = a;
        e.op2 = b;
        e.opr = s;
        e.res = exp_res;
        e.flg = model_flg(a, b, s);
        sb_q.push_back(e);
        enter = 1'b1;
        step();
        enter = 1'b0;
        sw = 16'h5A5A;
        n = 0;
        while (state !== 3'b101 && n < 5) begin
            step();
            n++;
        end
        g = sb_q.pop_front();
        total++;
        if (state !== 3'b101) $display("FAIL calc_state: got %b required 101", state);
        else passed++;
        total++;
        if (result !== g.res) $display("FAIL calc_result: got %h required %h", result, g.res);
        else passed++;
        total++;
        if ({op1, op2, operation} !== {g.op1, g.op2, g.opr})
            $display("FAIL calc_regs: got %h/%h/%h required %h/%h/%h",
                     op1, op2, operation, g.op1, g.op2, g.opr);
        else passed++;
`ifdef CALC_FLAGS_EN
        total++;
        if (flags !== g.flg) $display("FAIL calc_flags: got %b required %b", flags, g.flg);
        else passed++;
`endif
        step();
        total++;
        if (result !== g.res) $display("FAIL result_hold: got %h required %h", result, g.res);
        else passed++;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        sw     = 16'hFFFF;
        enter  = 1'b1;
        step();
        step();
        total++;
        if ({state, op1, op2, operation, result} !== 67'd0)
            $display("FAIL reset_values: got %b %h %h %h %h required all zero",
                     state, op1, op2, operation, result);
        else passed++;
`ifdef CALC_FLAGS_EN
        total++;
        if (flags !== 4'b0) $display("FAIL reset_flags: got %b required 0000", flags);
        else passed++;
`endif
        resetN = 1'b1;
        repeat (4) step();
        total++;
        if (state !== 3'b000) $display("FAIL held_enter_at_release: state=%b required 000", state);
        else passed++;
        enter = 1'b0;
        step();
    endtask

    task automatic test_op1_track();
        sw = 16'h0012;
        step();
        total++;
        if (op1 !== 16'h0012) $display("FAIL op1_track_a: got %h required 0012", op1);
        else passed++;
        sw = 16'h0013;
        step();
        total++;
        if (op1 !== 16'h0013) $display("FAIL op1_track_b: got %h required 0013", op1);
        else passed++;
        enter = 1'b1;
        step();
        sw = 16'h7777;
        total++;
        if (state !== 3'b001) $display("FAIL press_advance: state=%b required 001", state);
        else passed++;
        repeat (9) step();
        total++;
        if (state !== 3'b001) $display("FAIL held_single_press: state=%b required 001", state);
        else passed++;
        total++;
        if (op1 !== 16'h0013) $display("FAIL op1_frozen: got %h required 0013", op1);
        else passed++;
        enter = 1'b0;
        step();
    endtask

    task automatic test_alu();
        run_calc(16'hFFFF, 16'h0001, 16'h0000, 16'h0000);
        run_calc(16'h0003, 16'h0005, 16'hABC1, 16'hFFFE);
        run_calc(16'h7FFF, 16'h0001, 16'h0000, 16'h8000);
        run_calc(16'hF0F0, 16'h0FF0, 16'h0002, 16'h00F0);
        run_calc(16'hF0F0, 16'h0FF0, 16'h0003, 16'hFFF0);
        run_calc(16'h8000, 16'h0001, 16'h0001, 16'h7FFF);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] a, b, s;
            a = 16'($urandom);
            b = 16'($urandom);
            s = 16'($urandom);
            run_calc(a, b, s, model_res(a, b, s));
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] kept;
        goto_op1_edit();
        sw = 16'h1111;
        step();
        do_press();
        do_press();
        sw = 16'h2222;
        step();
        #2;
        resetN = 1'b0;
        #1;
        total++;
        if ({state, op1, op2, operation, result} !== 67'd0)
            $display("FAIL async_reset: got %b %h %h %h %h required all zero",
                     state, op1, op2, operation, result);
        else passed++;
        step();
        #3;
        resetN = 1'b1;
        step();
        run_calc(16'h4321, 16'h1234, 16'h0001, 16'h30ED);
        kept = op1;
        sw = 16'h5555;
        enter = 1'b1;
        step();
        enter = 1'b0;
        total++;
        if (state !== 3'b000 || op1 !== kept)
            $display("FAIL result_wrap: state=%b op1=%h required 000 op1=%h", state, op1, kept);
        else passed++;
        step();
        total++;
        if (op1 !== 16'h5555) $display("FAIL op1_resample: got %h required 5555", op1);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_op1_track();
        test_alu();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
